// File: rtl/parity_check_arbiter_pkg.sv
// Shared types and helpers for the parity check arbiter.
//   DATA_W       : width of one requester nibble
//   state_e      : arbiter FSM states
//   even_par_err : 1 when a {par, data} codeword violates even parity
package parity_arb_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_e;

  function automatic logic even_par_err(input logic [DATA_W:0] cw);
    return ^cw;
  endfunction

endpackage

// File: rtl/parity_check_arbiter_if.sv
// Request/result bus between the receive lanes, the arbiter and the
// error-reporting consumer.
//   req/req_data/req_par : per-requester codeword offer (lane i at index i)
//   req_ack              : one-cycle capture pulse back to the lane
//   res_*                : valid/ready result channel to the consumer
// slave  = arbiter side, master = lanes + consumer side.
interface parity_check_arbiter_if
  import parity_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_par;
  logic [NUM_REQ-1:0]             req_ack;
  logic                           res_valid;
  logic                           res_ready;
  logic [ID_W-1:0]                res_id;
  logic                           res_err;

  modport slave (
    input  req, req_data, req_par, res_ready,
    output req_ack, res_valid, res_id, res_err
  );

  modport master (
    output req, req_data, req_par, res_ready,
    input  req_ack, res_valid, res_id, res_err
  );

endinterface

// File: rtl/parity_check_arbiter_parity_unit.sv
// Combinational even-parity checker for one nibble codeword.
//   data_i : received nibble
//   par_i  : received even-parity bit
//   err_o  : 1 when XOR of data and parity is 1
module parity_unit
  import parity_arb_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic              par_i,
  output logic              err_o
);

  assign err_o = even_par_err({par_i, data_i});

endmodule

// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter sharing one even-parity checker among NUM_REQ lanes.
// One codeword per transaction: IDLE picks a lane and captures its
// codeword (ack pulse), CHECK computes the error and loads the result,
// RESP holds the result until the consumer takes it.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request/result interface (slave side)
//   err_clr  : synchronous clear of err_cnt, wins over an increment
//   err_cnt  : saturating count of errored codewords
//   busy     : high whenever the FSM is not in IDLE
module parity_check_arbiter
  import parity_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  parity_check_arbiter_if.slave bus,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 busy
);

  state_e              state_q;
  logic [ID_W-1:0]     rr_q;
  logic [DATA_W-1:0]   data_q;
  logic                par_q;
  logic [ID_W-1:0]     id_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                res_valid_q;
  logic [ID_W-1:0]     res_id_q;
  logic                res_err_q;
  logic [CNT_W-1:0]    err_cnt_q;
  logic                busy_q;

  // Round-robin pick: first requesting lane at or after rr_q, wrapping
  // modulo NUM_REQ (which need not be a power of two).
  logic                sel_found;
  logic [ID_W-1:0]     sel_id;
  logic [NUM_REQ-1:0]  ack_d;
  logic [ID_W:0]       cand;

  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!sel_found && bus.req[cand[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    ack_d         = '0;
    ack_d[sel_id] = 1'b1;
  end

  // Pointer moves past the lane just served so it loses to other pending lanes.
  logic [ID_W-1:0] rr_d;
  assign rr_d = (res_id_q == ID_W'(NUM_REQ-1)) ? '0 : res_id_q + ID_W'(1);

  // Checker works on the captured codeword, so lane changes after ack are ignored.
  logic par_err;

  parity_unit u_parity (
    .data_i (data_q),
    .par_i  (par_q),
    .err_o  (par_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      data_q      <= '0;
      par_q       <= 1'b0;
      id_q        <= '0;
      ack_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      ack_q <= '0;

      if (err_clr)
        err_cnt_q <= '0;
      else if (state_q == CHECK && par_err && err_cnt_q != '1)
        err_cnt_q <= err_cnt_q + CNT_W'(1);

      case (state_q)
        IDLE: begin
          if (sel_found) begin
            data_q  <= bus.req_data[sel_id];
            par_q   <= bus.req_par[sel_id];
            id_q    <= sel_id;
            ack_q   <= ack_d;
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          res_id_q    <= id_q;
          res_err_q   <= par_err;
          res_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            rr_q        <= rr_d;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ack   = ack_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_err   = res_err_q;
  assign err_cnt       = err_cnt_q;
  assign busy          = busy_q;

endmodule

// File: doc/parity_check_arbiter.md
Name: parity_check_arbiter

Overview:
- Shares one even-parity check unit among NUM_REQ requesters, each presenting a 4-bit data nibble plus a received even-parity bit.
- Round-robin arbitration; one codeword checked per transaction.
- The result (requester id, error flag) is delivered over a valid/ready handshake.
- A saturating error counter provides link-health monitoring.
- Sits between the nibble-level receive lanes and the error-reporting logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester id width (must satisfy 2**ID_W >= NUM_REQ).
- CNT_W, 8, error counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high until its ack.
- req_data  in  4*NUM_REQ  nibble for requester i at bits [4i+3:4i].
- req_par  in  NUM_REQ  received even-parity bit for requester i.
- req_ack  out  NUM_REQ  one-cycle pulse: codeword of requester i captured.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_id  out  ID_W  requester id of the result.
- res_err  out  1  1 = parity error, i.e. XOR(data, par) = 1.
- err_cnt  out  CNT_W  saturating count of errored codewords.
- err_clr  in  1  synchronous clear of err_cnt.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: req_ack=0, res_valid=0, res_id=0, res_err=0, err_cnt=0, busy=0, rr pointer=0, state=IDLE.
- All outputs are registered.
- FSM states are IDLE, CHECK and RESP.
- IDLE:
  - If any req bit is set, select the first set requester at or after the rr pointer, wrapping modulo NUM_REQ.
  - Latch its data, parity bit and id.
  - Pulse its req_ack for the next cycle.
  - Go to CHECK.
  - If no req bit is set, stay in IDLE.
- CHECK (one cycle):
  - Compute err = ^{data, par}.
  - Load res_id and res_err.
  - Set res_valid=1.
  - If err=1, increment err_cnt.
  - Go to RESP.
- RESP:
  - Hold res_valid, res_id and res_err stable until res_valid & res_ready.
  - On the handshake: clear res_valid, set rr pointer = (res_id+1) mod NUM_REQ, go to IDLE.
- Latency and throughput:
  - Request sampled at cycle T → req_ack at T+1 → res_valid at T+2.
  - If res_ready is already high at T+2, the next arbitration happens at T+3.
  - Peak throughput is one codeword per 3 cycles.
- Arbitration and request rules:
  - Requests are sampled only in IDLE.
  - A req that drops before being sampled is ignored.
  - A requester may reassert req on the cycle after its ack; it will not win again while other requesters are pending.
  - req_data and req_par changes after ack have no effect on the captured codeword.
- err_cnt rules:
  - Saturates at 2**CNT_W-1 and never wraps.
  - err_clr has priority over a simultaneous increment; the counter reads 0 on the following cycle.
- Reset mid-transaction: the FSM returns to IDLE, the pending result is discarded and err_cnt is cleared.
- busy = (state != IDLE).

Decomposition:
- Package parity_arb_pkg holds:
  - state enum {IDLE, CHECK, RESP};
  - DATA_W=4;
  - a function for the even-parity error of a {par, data} codeword.
- Sub-module parity_unit: purely combinational, 4-bit data + parity in, err out. It is instantiated once inside the arbiter.
- Round-robin select logic stays inline.

Test Plan:
- Single request: req=0001, data=4'b1011, par=1 → ack=0001 at T+1; res_valid at T+2 with res_id=0, res_err=0; err_cnt stays 0.
- Error detect: requester 2, data=4'b1011, par=0 → res_id=2, res_err=1, err_cnt=1.
- Round-robin fairness: req=1111 held high, re-requesting after each ack, res_ready=1 → grant order 0,1,2,3,0, with acks 3 cycles apart.
- Backpressure: res_ready=0 for 5 cycles after res_valid → res_id and res_err stay stable, busy=1, no new ack; res_ready=1 → return to IDLE.
- Counter saturation and clear:
  - Preload via 255 errored codewords, then one more error → err_cnt stays 255.
  - err_clr asserted in the same cycle as an increment → err_cnt=0.
- Reset in RESP: rst=1 while res_valid=1 → next cycle res_valid=0, err_cnt=0, state IDLE, rr pointer=0.
